// File: rtl/rom_prefetch_queue_if.sv
// Bundles the ROM port and the consumer port of the instruction prefetch queue.
// The slave modport is the queue; the master modport is the ROM plus CPU fetch side.
interface rom_prefetch_queue_if #(
  parameter int WORD_SIZE = 8,
  parameter int NBIT      = 15,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NBIT-1:0]      rom_addr;
  logic                 rom_nCE;
  logic [WORD_SIZE-1:0] rom_data;

  logic                 pc_load;
  logic [NBIT-1:0]      pc_target;
  logic                 rd_en;
  logic [WORD_SIZE-1:0] data_out;
  logic [NBIT-1:0]      data_pc;
  logic                 data_valid;
  logic [CW-1:0]        count;

  modport slave (
    output rom_addr, rom_nCE, data_out, data_pc, data_valid, count,
    input  rom_data, pc_load, pc_target, rd_en
  );

  modport master (
    input  rom_addr, rom_nCE, data_out, data_pc, data_valid, count,
    output rom_data, pc_load, pc_target, rd_en
  );
endinterface

// File: rtl/rom_prefetch_queue.sv
// Sequential ROM prefetcher feeding a DEPTH-entry {byte, address} FIFO; pc_load redirects and flushes.
// Optional macro PREFETCH_STATS_EN adds a saturating 16-bit flush_count output.
module rom_prefetch_queue #(
  parameter int              WORD_SIZE  = 8,
  parameter int              NBIT       = 15,
  parameter int              DEPTH      = 4,
  parameter logic [NBIT-1:0] RESET_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    nRST,
`ifdef PREFETCH_STATS_EN
  output logic [15:0]             flush_count,
`endif
  rom_prefetch_queue_if.slave     bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [NBIT-1:0]      fetch_ptr, fetch_ptr_next;
  logic [PW-1:0]        wr_ptr, wr_ptr_next;
  logic [PW-1:0]        rd_ptr, rd_ptr_next;
  logic [CW-1:0]        count, count_next;
  logic                 push, pop;
  logic                 valid;

  logic [WORD_SIZE-1:0] mem_data [DEPTH];
  logic [NBIT-1:0]      mem_addr [DEPTH];

  assign valid = (count != '0);

  // Control: redirect dominates; a full queue only accepts a byte when the head leaves.
  always_comb begin
    pop            = 1'b0;
    push           = 1'b0;
    state_next     = state;
    fetch_ptr_next = fetch_ptr;
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    count_next     = count;

    if (bus.pc_load) begin
      state_next     = FILL;
      fetch_ptr_next = bus.pc_target;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
    end else begin
      pop  = bus.rd_en && valid;
      push = (state == FILL) || pop;

      if (push) begin
        fetch_ptr_next = fetch_ptr + 1'b1;
        wr_ptr_next    = wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase

      state_next = (count_next == FULL_COUNT) ? FULL : FILL;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= FILL;
      fetch_ptr <= RESET_ADDR;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      fetch_ptr <= fetch_ptr_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.rom_data;
      mem_addr[wr_ptr] <= fetch_ptr;
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      flush_count <= '0;
    end else if (bus.pc_load && (flush_count != 16'hFFFF)) begin
      flush_count <= flush_count + 16'd1;
    end
  end
`endif

  assign bus.rom_addr   = fetch_ptr;
  assign bus.rom_nCE    = !push;
  assign bus.data_out   = mem_data[rd_ptr];
  assign bus.data_pc    = mem_addr[rd_ptr];
  assign bus.data_valid = valid;
  assign bus.count      = count;

endmodule
